// File: rtl/blink_pkg.sv
// Shared mode encoding and reset defaults for the multi-channel LED blinker.
// Pure declarations: no latency, no flow control.
package blink_pkg;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_ON    = 2'd1,
    MODE_BLINK = 2'd2,
    MODE_PWM   = 2'd3
  } mode_t;

  localparam mode_t RST_MODE = MODE_OFF;
  localparam logic  RST_LED  = 1'b0;
  localparam logic  RST_ERR  = 1'b0;

endpackage

// File: rtl/blink_channel.sv
// One LED channel: mode/arg/phase registers and a registered LED output.
// Load at edge k shows on the LED at edge k+1; always accepts a load.
module blink_channel
  import blink_pkg::*;
#(
  parameter int CNT_W = 24,
  parameter int PWM_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic             i_clear,
  input  mode_t            i_mode,
  input  logic [PWM_W-1:0] i_arg,
  output logic             o_led
);

  localparam int TAP_W = $clog2(CNT_W);

  mode_t            r_mode;
  logic [PWM_W-1:0] r_arg;
  logic [CNT_W-1:0] r_phase;
  logic             r_led;

  logic [31:0]      w_arg32;
  logic [TAP_W-1:0] w_tap;
  logic             w_led_nxt;

  // Out-of-range taps saturate to the counter MSB instead of aliasing.
  assign w_arg32 = 32'(r_arg);
  assign w_tap   = (w_arg32 > 32'(CNT_W - 1)) ? TAP_W'(CNT_W - 1) : TAP_W'(w_arg32);

  always_comb begin
    w_led_nxt = RST_LED;
    case (r_mode)
      MODE_OFF:   w_led_nxt = 1'b0;
      MODE_ON:    w_led_nxt = 1'b1;
      MODE_BLINK: w_led_nxt = r_phase[w_tap];
      MODE_PWM:   w_led_nxt = (r_phase[PWM_W-1:0] < r_arg);
      default:    w_led_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mode  <= RST_MODE;
      r_arg   <= '0;
      r_phase <= '0;
      r_led   <= RST_LED;
    end else begin
      if (i_load) begin
        r_mode <= i_mode;
        r_arg  <= i_arg;
      end
      if (i_load || i_clear) r_phase <= '0;
      else                   r_phase <= r_phase + CNT_W'(1);
      r_led <= w_led_nxt;
    end
  end

  assign o_led = r_led;

endmodule

// File: rtl/blink_multi.sv
// NUM_CH LED channels configured through a write port; sync_all realigns every phase.
// Write at edge k affects led at edge k+1; cfg_ready is high whenever out of reset.
module blink_multi
  import blink_pkg::*;
#(
  parameter  int NUM_CH = 4,
  parameter  int CNT_W  = 24,
  parameter  int PWM_W  = 8,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_12mhz,
  input  logic              rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [1:0]        cfg_mode,
  input  logic [PWM_W-1:0]  cfg_arg,
  output logic              cfg_err,
  input  logic              sync_all,
  output logic [NUM_CH-1:0] led
);

  logic w_accept;
  logic w_in_range;
  logic r_err;

  assign cfg_ready  = ~rst;
  assign w_accept   = cfg_valid && cfg_ready;
  assign w_in_range = (32'(cfg_ch) < 32'(NUM_CH));

  always_ff @(posedge clk_12mhz) begin
    if (rst) r_err <= RST_ERR;
    else     r_err <= w_accept && !w_in_range;
  end

  assign cfg_err = r_err;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic w_load;
    assign w_load = w_accept && w_in_range && (cfg_ch == CH_W'(g));

    blink_channel #(
      .CNT_W (CNT_W),
      .PWM_W (PWM_W)
    ) u_ch (
      .clk     (clk_12mhz),
      .rst     (rst),
      .i_load  (w_load),
      .i_clear (sync_all),
      .i_mode  (mode_t'(cfg_mode)),
      .i_arg   (cfg_arg),
      .o_led   (led[g])
    );
  end

endmodule

// File: tb/tb_blink_multi.sv
// Bench for blink_multi (3 channels so an out-of-range index exists).
// Reference model tracks each channel's clear time and derives LED values from elapsed cycles.
module tb_blink_multi;

  localparam int NCH   = 3;
  localparam int CNT_W = 24;
  localparam int PWM_W = 8;

  logic           clk_12mhz = 1'b0;
  logic           rst;
  logic           cfg_valid;
  logic           cfg_ready;
  logic [1:0]     cfg_ch;
  logic [1:0]     cfg_mode;
  logic [7:0]     cfg_arg;
  logic           cfg_err;
  logic           sync_all;
  logic [NCH-1:0] led;

  always #5 clk_12mhz = ~clk_12mhz;

  blink_multi #(
    .NUM_CH (NCH),
    .CNT_W  (CNT_W),
    .PWM_W  (PWM_W)
  ) dut (
    .clk_12mhz (clk_12mhz),
    .rst       (rst),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_mode  (cfg_mode),
    .cfg_arg   (cfg_arg),
    .cfg_err   (cfg_err),
    .sync_all  (sync_all),
    .led       (led)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // model: per-channel mode, argument and the edge index at which its phase was last cleared
  int unsigned m_mode [NCH];
  int unsigned m_arg  [NCH];
  longint      m_clr  [NCH];
  longint      e = 0;

  logic [NCH-1:0] exp_led;
  logic           exp_err;
  logic           exp_rdy;

  task automatic cyc(input logic r, input logic v, input int ch, input int md,
                     input int ag, input logic s);
    longint ph;
    int unsigned tap;
    rst       = r;
    cfg_valid = v;
    cfg_ch    = 2'(ch);
    cfg_mode  = 2'(md);
    cfg_arg   = 8'(ag);
    sync_all  = s;
    @(posedge clk_12mhz);
    e++;
    if (r) begin
      exp_led = '0;
      exp_err = 1'b0;
      for (int i = 0; i < NCH; i++) begin
        m_mode[i] = 0;
        m_arg[i]  = 0;
        m_clr[i]  = e;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        ph = (e - 1 - m_clr[i]) % (longint'(1) << CNT_W);
        case (m_mode[i])
          0: exp_led[i] = 1'b0;
          1: exp_led[i] = 1'b1;
          2: begin
            tap = (m_arg[i] > CNT_W - 1) ? CNT_W - 1 : m_arg[i];
            exp_led[i] = ((ph >> tap) & 1) != 0;
          end
          default: exp_led[i] = (ph % 256) < m_arg[i];
        endcase
      end
      exp_err = v && (ch >= NCH);
      if (s) for (int i = 0; i < NCH; i++) m_clr[i] = e;
      if (v && ch < NCH) begin
        m_mode[ch] = md;
        m_arg[ch]  = ag;
        m_clr[ch]  = e;
      end
    end
    exp_rdy = !r;
    #1;
    n_assert++;
    assert (led === exp_led)
      else begin n_fail++; $error("FAIL led edge=%0d got=%b exp=%b", e, led, exp_led); end
    n_assert++;
    assert (cfg_err === exp_err)
      else begin n_fail++; $error("FAIL cfg_err edge=%0d got=%b exp=%b", e, cfg_err, exp_err); end
    n_assert++;
    assert (cfg_ready === exp_rdy)
      else begin n_fail++; $error("FAIL cfg_ready edge=%0d got=%b exp=%b", e, cfg_ready, exp_rdy); end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 0, 0, 0, 1'b0);
  endtask

  task automatic wr(input int ch, input int md, input int ag);
    cyc(1'b0, 1'b1, ch, md, ag, 1'b0);
  endtask

  // after a PWM write, count high cycles of led[0] over one 256-cycle period
  task automatic pwm_count(input int duty);
    int cnt;
    wr(0, 3, duty);
    cnt = 0;
    for (int i = 0; i < 256; i++) begin
      idle(1);
      cnt += int'(led[0]);
    end
    n_assert++;
    assert (cnt === duty)
      else begin n_fail++; $error("FAIL pwm_high duty=%0d got=%0d exp=%0d", duty, cnt, duty); end
  endtask

  initial begin
    int ch, md, ag, gap;
    logic s;

    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 0, 0, 0, 1'b0);
    idle(2);

    // blink with tap 2: four low, four high
    wr(1, 2, 2);
    idle(20);

    pwm_count(64);
    pwm_count(0);
    pwm_count(255);
    idle(4);

    // out-of-range index, then ON/OFF toggles
    wr(3, 1, 0);
    idle(2);
    wr(2, 1, 0);
    idle(2);
    wr(2, 0, 0);
    idle(2);

    // two blinkers at different phases, realigned by sync_all
    wr(0, 2, 3);
    idle(5);
    wr(2, 2, 3);
    idle(7);
    cyc(1'b0, 1'b0, 0, 0, 0, 1'b1);
    idle(40);
    cyc(1'b0, 1'b1, 2, 3, 100, 1'b1);
    idle(30);

    for (int k = 0; k < 40; k++) begin
      ch  = int'($urandom_range(0, 3));
      md  = int'($urandom_range(0, 3));
      ag  = (md == 2) ? int'($urandom_range(0, 6)) : int'($urandom_range(0, 255));
      s   = ($urandom_range(0, 7) == 0);
      gap = int'($urandom_range(1, 40));
      cyc(1'b0, 1'b1, ch, md, ag, s);
      idle(gap);
    end

    // reset in the middle of a PWM run, with a write that must be dropped
    wr(0, 3, 128);
    idle(10);
    cyc(1'b1, 1'b1, 1, 1, 0, 1'b0);
    idle(10);

    // tap 200 saturates to the counter MSB: stays low for a long time
    wr(1, 2, 200);
    idle(600);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
